// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: pops a FWFT instruction FIFO, forwards config words to the decoder,
// launches NPU layers once IOB2N/WB2N/N2IOB are all configured, and waits on completion with a timeout.
module inst_dispatcher #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr_err,
  input  logic [127:0] inst_data,
  input  logic         inst_empty,
  output logic         inst_rd_en,
  output logic [127:0] dec_inst,
  output logic         dec_valid,
  output logic         npu_start,
  input  logic         npu_done,
  output logic         busy,
  output logic         layer_done,
  output logic         prog_done,
  output logic [15:0]  layer_cnt,
  output logic [1:0]   err_code
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [4:0] OP_IOB2N = 5'b01010;
  localparam logic [4:0] OP_WB2N  = 5'b01011;
  localparam logic [4:0] OP_N2IOB = 5'b01101;
  localparam logic [4:0] OP_RUN   = 5'b00001;
  localparam logic [4:0] OP_END   = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_HALT
  } state_t;

  state_t          state, state_n;
  logic [2:0]      cfg, cfg_n;
  logic [CW-1:0]   tmo_cnt, tmo_n, tmo_inc;
  logic [1:0]      err_n;
  logic [15:0]     cnt_n;
  logic            dv_n, st_n, ld_n, pd_n, load, pop;
  logic [4:0]      op;

  assign op      = inst_data[127:123];
  assign tmo_inc = tmo_cnt + CW'(1);

  always_comb begin
    state_n = state;
    cfg_n   = cfg;
    tmo_n   = tmo_cnt;
    err_n   = err_code;
    cnt_n   = layer_cnt;
    dv_n    = 1'b0;
    st_n    = 1'b0;
    ld_n    = 1'b0;
    pd_n    = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !inst_empty) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (!en) begin
          state_n = S_IDLE;
        end else if (!inst_empty) begin
          pop = 1'b1;
          case (op)
            OP_IOB2N: begin cfg_n[0] = 1'b1; dv_n = 1'b1; load = 1'b1; end
            OP_WB2N:  begin cfg_n[1] = 1'b1; dv_n = 1'b1; load = 1'b1; end
            OP_N2IOB: begin cfg_n[2] = 1'b1; dv_n = 1'b1; load = 1'b1; end
            OP_RUN: begin
              if (&cfg) begin
                st_n    = 1'b1;
                state_n = S_LAUNCH;
              end else begin
                err_n   = 2'd1;
                state_n = S_HALT;
              end
            end
            OP_END: begin
              pd_n    = 1'b1;
              cfg_n   = 3'b000;
              state_n = S_IDLE;
            end
            default: begin
              err_n   = 2'd2;
              state_n = S_HALT;
            end
          endcase
        end
      end
      S_LAUNCH: begin
        cfg_n   = 3'b000;
        tmo_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        tmo_n = tmo_inc;
        // Completion takes priority over a timeout landing in the same cycle.
        if (npu_done) begin
          ld_n    = 1'b1;
          cnt_n   = layer_cnt + 16'd1;
          state_n = S_FETCH;
        end else if (tmo_inc == CW'(TIMEOUT_CYC)) begin
          err_n   = 2'd3;
          state_n = S_HALT;
        end
      end
      S_HALT: begin
        if (clr_err) begin
          err_n   = 2'd0;
          cfg_n   = 3'b000;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign inst_rd_en = pop && !rst;
  assign busy       = (state != S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg        <= 3'b000;
      tmo_cnt    <= '0;
      err_code   <= 2'd0;
      layer_cnt  <= 16'd0;
      dec_inst   <= 128'd0;
      dec_valid  <= 1'b0;
      npu_start  <= 1'b0;
      layer_done <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      state      <= state_n;
      cfg        <= cfg_n;
      tmo_cnt    <= tmo_n;
      err_code   <= err_n;
      layer_cnt  <= cnt_n;
      dec_valid  <= dv_n;
      npu_start  <= st_n;
      layer_done <= ld_n;
      prog_done  <= pd_n;
      if (load) dec_inst <= inst_data;
    end
  end

endmodule

// File: tb/tb_inst_dispatcher.sv
// Directed bench: cycle-by-cycle vector table on a default-timeout instance, plus
// timeout / tie / mid-layer reset sequences on an instance with TIMEOUT_CYC=8.
module tb_inst_dispatcher;

  localparam logic [4:0] OI = 5'b01010;
  localparam logic [4:0] OW = 5'b01011;
  localparam logic [4:0] ON = 5'b01101;
  localparam logic [4:0] OR = 5'b00001;
  localparam logic [4:0] OE = 5'b11111;
  localparam logic [4:0] OX = 5'b00111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic         en = 1'b0, clr = 1'b0, empty = 1'b1, done = 1'b0;
  logic [4:0]   op = 5'd0;
  logic [7:0]   tag = 8'd0;
  logic [127:0] data, dec;
  logic         rd, dv, st, bsy, ld, pd;
  logic [15:0]  cnt;
  logic [1:0]   err;
  assign data = {op, 115'd0, tag};

  inst_dispatcher dut (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr), .inst_data(data), .inst_empty(empty),
    .inst_rd_en(rd), .dec_inst(dec), .dec_valid(dv), .npu_start(st), .npu_done(done),
    .busy(bsy), .layer_done(ld), .prog_done(pd), .layer_cnt(cnt), .err_code(err)
  );

  // short-timeout instance
  logic         t_en = 1'b0, t_clr = 1'b0, t_empty = 1'b1, t_done = 1'b0;
  logic [4:0]   t_op = 5'd0;
  logic [127:0] t_data, t_dec;
  logic         t_rd, t_dv, t_st, t_bsy, t_ld, t_pd;
  logic [15:0]  t_cnt;
  logic [1:0]   t_err;
  assign t_data = {t_op, 123'd0};

  inst_dispatcher #(.TIMEOUT_CYC(8)) dut_t (
    .clk(clk), .rst(rst), .en(t_en), .clr_err(t_clr), .inst_data(t_data), .inst_empty(t_empty),
    .inst_rd_en(t_rd), .dec_inst(t_dec), .dec_valid(t_dv), .npu_start(t_st), .npu_done(t_done),
    .busy(t_bsy), .layer_done(t_ld), .prog_done(t_pd), .layer_cnt(t_cnt), .err_code(t_err)
  );

  typedef struct {
    logic       en, clr, empty, done;
    logic [4:0] op;
    logic [7:0] tag;
    logic       rd, busy, dv, st, ld, pd;
    logic [1:0] err;
    logic [15:0] cnt;
    logic [4:0] dop;
    logic [7:0] dtag;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nmis = 0;

  // inputs for this cycle; expected outputs seen at the falling edge of the same cycle
  task automatic v(input int i_en, i_clr, i_empty, i_done, i_op, i_tag,
                   input int e_rd, e_busy, e_dv, e_st, e_ld, e_pd, e_err, e_cnt, e_dop, e_dtag);
    vec_t x;
    x.en = 1'(i_en);     x.clr = 1'(i_clr);   x.empty = 1'(i_empty); x.done = 1'(i_done);
    x.op = 5'(i_op);     x.tag = 8'(i_tag);
    x.rd = 1'(e_rd);     x.busy = 1'(e_busy); x.dv = 1'(e_dv);       x.st = 1'(e_st);
    x.ld = 1'(e_ld);     x.pd = 1'(e_pd);     x.err = 2'(e_err);     x.cnt = 16'(e_cnt);
    x.dop = 5'(e_dop);   x.dtag = 8'(e_dtag);
    vq.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [151:0] act, input logic [151:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drive dut_t from IDLE or FETCH through a full config set and RUN into WAIT_DONE
  task automatic t_to_wait;
    t_en = 1'b1; t_empty = 1'b0; t_op = OI;
    tick; tick;
    t_op = OW; tick;
    t_op = ON; tick;
    t_op = OR; tick;
    t_empty = 1'b1; tick;
  endtask

  initial begin
    // en clr emp done op tag | rd busy dv st ld pd err cnt dop dtag
    v(0,0,1,0, 0,0,  0,0,0,0,0,0, 0,0, 0,0);
    v(1,0,0,0, OI,1, 0,0,0,0,0,0, 0,0, 0,0);
    v(1,0,0,0, OI,1, 1,1,0,0,0,0, 0,0, 0,0);
    v(1,0,0,0, OW,2, 1,1,1,0,0,0, 0,0, OI,1);
    v(1,0,0,0, ON,3, 1,1,1,0,0,0, 0,0, OW,2);
    v(1,0,0,0, OR,4, 1,1,1,0,0,0, 0,0, ON,3);
    v(1,0,0,0, OE,5, 0,1,0,1,0,0, 0,0, ON,3);
    for (int i = 0; i < 9; i++) v(1,0,0,0, OE,5, 0,1,0,0,0,0, 0,0, ON,3);
    v(1,0,0,1, OE,5, 0,1,0,0,0,0, 0,0, ON,3);
    v(1,0,0,0, OE,5, 1,1,0,0,1,0, 0,1, ON,3);
    v(1,0,1,0, OE,5, 0,0,0,0,0,1, 0,1, ON,3);
    v(1,0,1,0, OE,5, 0,0,0,0,0,0, 0,1, ON,3);
    // RUN with incomplete config, then clear
    v(1,0,0,0, OI,6, 0,0,0,0,0,0, 0,1, ON,3);
    v(1,0,0,0, OI,6, 1,1,0,0,0,0, 0,1, ON,3);
    v(1,0,0,0, OR,7, 1,1,1,0,0,0, 0,1, OI,6);
    v(1,0,1,0, OR,7, 0,1,0,0,0,0, 1,1, OI,6);
    v(1,0,1,0, OR,7, 0,1,0,0,0,0, 1,1, OI,6);
    v(1,1,1,0, OR,7, 0,1,0,0,0,0, 1,1, OI,6);
    v(1,0,1,0, OR,7, 0,0,0,0,0,0, 0,1, OI,6);
    // illegal opcode
    v(1,0,0,0, OX,8, 0,0,0,0,0,0, 0,1, OI,6);
    v(1,0,0,0, OX,8, 1,1,0,0,0,0, 0,1, OI,6);
    v(1,0,1,0, OX,8, 0,1,0,0,0,0, 2,1, OI,6);
    v(1,1,1,0, OX,8, 0,1,0,0,0,0, 2,1, OI,6);
    v(1,0,1,0, OX,8, 0,0,0,0,0,0, 0,1, OI,6);
    // en dropped while FETCH starves; stray npu_done in IDLE
    v(1,0,0,0, OI,9, 0,0,0,0,0,0, 0,1, OI,6);
    v(1,0,1,0, OI,9, 0,1,0,0,0,0, 0,1, OI,6);
    v(1,0,1,0, OI,9, 0,1,0,0,0,0, 0,1, OI,6);
    v(0,0,0,0, OI,9, 0,1,0,0,0,0, 0,1, OI,6);
    v(0,0,0,1, OI,9, 0,0,0,0,0,0, 0,1, OI,6);
    v(0,0,0,0, OI,9, 0,0,0,0,0,0, 0,1, OI,6);
    // repeated config, en dropped during WAIT_DONE
    v(1,0,0,0, OI,10, 0,0,0,0,0,0, 0,1, OI,6);
    v(1,0,0,0, OI,10, 1,1,0,0,0,0, 0,1, OI,6);
    v(1,0,0,0, OI,11, 1,1,1,0,0,0, 0,1, OI,10);
    v(1,0,0,0, OW,12, 1,1,1,0,0,0, 0,1, OI,11);
    v(1,0,0,0, ON,13, 1,1,1,0,0,0, 0,1, OW,12);
    v(1,0,0,0, OR,14, 1,1,1,0,0,0, 0,1, ON,13);
    v(0,0,1,0, OR,14, 0,1,0,1,0,0, 0,1, ON,13);
    v(0,0,1,0, OR,14, 0,1,0,0,0,0, 0,1, ON,13);
    v(0,0,1,1, OR,14, 0,1,0,0,0,0, 0,1, ON,13);
    v(0,0,1,0, OR,14, 0,1,0,0,1,0, 0,2, ON,13);
    v(0,0,1,0, OR,14, 0,0,0,0,0,0, 0,2, ON,13);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; clr = vq[i].clr; empty = vq[i].empty; done = vq[i].done;
      op = vq[i].op; tag = vq[i].tag;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {rd, bsy, dv, st, ld, pd, err, cnt, dec},
          {vq[i].rd, vq[i].busy, vq[i].dv, vq[i].st, vq[i].ld, vq[i].pd, vq[i].err, vq[i].cnt,
           vq[i].dop, 115'd0, vq[i].dtag});
      @(posedge clk);
      #1;
    end
    en = 1'b0; empty = 1'b1; done = 1'b0; clr = 1'b0;

    // timeout after 8 WAIT_DONE cycles
    chk("t_reset", 152'({t_bsy, t_err, t_cnt}), 152'(0));
    t_to_wait();
    repeat (7) tick;
    chk("tmo_early", 152'({t_err, t_bsy}), 152'({2'd0, 1'b1}));
    tick;
    chk("tmo_err", 152'({t_err, t_bsy, t_ld}), 152'({2'd3, 1'b1, 1'b0}));
    t_clr = 1'b1; tick; t_clr = 1'b0;
    chk("tmo_clr", 152'({t_err, t_bsy}), 152'(0));

    // npu_done on the timeout cycle wins
    t_to_wait();
    repeat (7) tick;
    t_done = 1'b1; tick; t_done = 1'b0;
    chk("tie_done", 152'({t_err, t_ld, t_cnt}), 152'({2'd0, 1'b1, 16'd1}));

    // reset mid-layer abandons it
    t_to_wait();
    tick; tick;
    chk("pre_rst_wait", 152'({t_bsy, t_rd, t_err}), 152'({1'b1, 1'b0, 2'd0}));
    t_empty = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async", {t_rd, t_bsy, t_dv, t_st, t_ld, t_pd, t_err, t_cnt, t_dec}, 152'(0));
    chk("rst_main_cnt", 152'({cnt, bsy}), 152'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    t_en = 1'b0;
    t_done = 1'b1; tick; t_done = 1'b0; tick;
    chk("rst_no_layer", 152'({t_cnt, t_ld, t_bsy, t_err}), 152'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
